// File: rtl/pia_bus_arbiter.sv
// Two-requester (CPU / host) arbiter in front of a PIA register port.
// Each access takes three cycles: arbitrate in IDLE, strobe in ISSUE, acknowledge in CAPTURE.
module pia_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cpu_req_i,
    input  logic       cpu_we_i,
    input  logic [6:0] cpu_adr_i,
    input  logic [7:0] cpu_dat_i,
    output logic       cpu_ack_o,
    output logic [7:0] cpu_dat_o,
    input  logic       host_req_i,
    input  logic       host_we_i,
    input  logic [6:0] host_adr_i,
    input  logic [7:0] host_dat_i,
    output logic       host_ack_o,
    output logic [7:0] host_dat_o,
    output logic       pia_stb_o,
    output logic       pia_we_o,
    output logic [6:0] pia_adr_o,
    output logic [7:0] pia_dat_o,
    input  logic [7:0] pia_dat_i,
    output logic       busy_o
);

    // state   | meaning
    // IDLE    | sample requests, arbitrate, latch winner's command
    // ISSUE   | strobe latched command to the PIA
    // CAPTURE | ack the granted requester, return read data
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic       gnt_host_q, gnt_host_d;
    logic       cmd_we_q, cmd_we_d;
    logic [6:0] cmd_adr_q, cmd_adr_d;
    logic [7:0] cmd_dat_q, cmd_dat_d;
    logic [3:0] starve_q, starve_d;
    logic [7:0] cpu_dat_q, cpu_dat_d;
    logic [7:0] host_dat_q, host_dat_d;

    always_comb begin
        state_d    = state_q;
        gnt_host_d = gnt_host_q;
        cmd_we_d   = cmd_we_q;
        cmd_adr_d  = cmd_adr_q;
        cmd_dat_d  = cmd_dat_q;
        starve_d   = starve_q;
        cpu_dat_d  = cpu_dat_q;
        host_dat_d = host_dat_q;
        case (state_q)
            IDLE: begin
                if (cpu_req_i || host_req_i) begin
                    state_d = ISSUE;
                    if (host_req_i && (!cpu_req_i || starve_q >= LIMIT)) begin
                        gnt_host_d = 1'b1;
                        cmd_we_d   = host_we_i;
                        cmd_adr_d  = host_adr_i;
                        cmd_dat_d  = host_dat_i;
                        starve_d   = 4'd0;
                    end else begin
                        gnt_host_d = 1'b0;
                        cmd_we_d   = cpu_we_i;
                        cmd_adr_d  = cpu_adr_i;
                        cmd_dat_d  = cpu_dat_i;
                        // only a contested CPU win counts toward host starvation
                        if (host_req_i) starve_d = starve_q + 4'd1;
                    end
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                state_d = IDLE;
                if (!cmd_we_q) begin
                    if (gnt_host_q) host_dat_d = pia_dat_i;
                    else            cpu_dat_d  = pia_dat_i;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            gnt_host_q <= 1'b0;
            cmd_we_q   <= 1'b0;
            cmd_adr_q  <= '0;
            cmd_dat_q  <= '0;
            starve_q   <= '0;
            cpu_dat_q  <= '0;
            host_dat_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_host_q <= gnt_host_d;
            cmd_we_q   <= cmd_we_d;
            cmd_adr_q  <= cmd_adr_d;
            cmd_dat_q  <= cmd_dat_d;
            starve_q   <= starve_d;
            cpu_dat_q  <= cpu_dat_d;
            host_dat_q <= host_dat_d;
        end
    end

    // Outputs decode straight from registers, so reset kills strobe/ack without a clock.
    assign pia_stb_o  = (state_q == ISSUE);
    assign pia_we_o   = pia_stb_o & cmd_we_q;
    assign pia_adr_o  = pia_stb_o ? cmd_adr_q : 7'd0;
    assign pia_dat_o  = pia_stb_o ? cmd_dat_q : 8'd0;
    assign cpu_ack_o  = (state_q == CAPTURE) & ~gnt_host_q;
    assign host_ack_o = (state_q == CAPTURE) &  gnt_host_q;
    assign busy_o     = (state_q != IDLE);

    // PIA read data only becomes valid in CAPTURE, so pass it through while ack is high
    assign cpu_dat_o  = (cpu_ack_o  && !cmd_we_q) ? pia_dat_i : cpu_dat_q;
    assign host_dat_o = (host_ack_o && !cmd_we_q) ? pia_dat_i : host_dat_q;

endmodule

// File: doc/pia_bus_arbiter.md
PIA_BUS_ARBITER -- requirements
Module: pia_bus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, range 1..15: consecutive contested CPU grants before the host is forced a grant.
REQ-002 Port clk_i  input  1  single system clock; all logic on its rising edge.
REQ-003 Port rst_i  input  1  reset, asynchronous assert, active-low.
REQ-004 Port cpu_req_i  input  1  CPU access request, level, held until cpu_ack_o.
REQ-005 Port cpu_we_i  input  1  CPU write (1) / read (0).
REQ-006 Port cpu_adr_i  input  7  CPU PIA register address.
REQ-007 Port cpu_dat_i  input  8  CPU write data.
REQ-008 Port cpu_ack_o  output  1  one-cycle completion pulse to CPU.
REQ-009 Port cpu_dat_o  output  8  CPU read data, valid with cpu_ack_o, held until next CPU read completes.
REQ-010 Port host_req_i, host_we_i, host_adr_i[6:0], host_dat_i[7:0]  inputs  host (OSD/loader) request bundle, same semantics as CPU.
REQ-011 Port host_ack_o  output  1, host_dat_o  output  8  host completion pulse and read data, same semantics as CPU.
REQ-012 Port pia_stb_o  output  1  strobe to PIA.
REQ-013 Port pia_we_o  output  1, pia_adr_o  output  7, pia_dat_o  output  8  PIA command bundle.
REQ-014 Port pia_dat_i  input  8  PIA registered read data, valid the cycle after pia_stb_o.
REQ-015 Port busy_o  output  1  high whenever FSM not IDLE.

Function
REQ-016 FSM states IDLE, ISSUE, CAPTURE; IDLE->ISSUE on any granted request; ISSUE->CAPTURE unconditionally; CAPTURE->IDLE unconditionally.
REQ-017 In IDLE: only cpu_req_i -> grant CPU; only host_req_i -> grant host; neither -> stay IDLE.
REQ-018 Both requesting in IDLE: grant CPU if starve_cnt < STARVE_LIMIT, else grant host.
REQ-019 starve_cnt: 4-bit; +1 on contested CPU grant; cleared on any host grant; unchanged on uncontested CPU grant; never exceeds STARVE_LIMIT.
REQ-020 On grant, winner's we/adr/dat latched into internal command register in the IDLE->ISSUE transition cycle; later requester-input changes have no effect on that access.
REQ-021 ISSUE: pia_stb_o=1 for exactly one cycle, pia_we_o/adr_o/dat_o driven from command register.
REQ-022 Outside ISSUE: pia_stb_o, pia_we_o, pia_adr_o, pia_dat_o all 0.
REQ-023 CAPTURE: granted port's ack pulses 1 for exactly one cycle; for reads, pia_dat_i is captured into that port's dat_o on the same edge ack rises; writes leave both dat_o unchanged.
REQ-024 Latency: request sampled in IDLE at edge N -> pia_stb_o high cycle N+1 -> ack high cycle N+2; one access per 3 cycles maximum.
REQ-025 Requester SHALL deassert req in the cycle after ack; arbiter samples requests only in IDLE, so a held req after ack yields a second access.
REQ-026 Non-granted requester's ack stays 0; its pending request is retained and arbitrated at next IDLE.
REQ-027 cpu_ack_o and host_ack_o never high in the same cycle.
REQ-028 Requests arriving in ISSUE or CAPTURE are ignored until IDLE.

Reset
REQ-029 rst_i low: asynchronously force state IDLE, starve_cnt 0, command register 0, all outputs 0 (cpu_ack_o, host_ack_o, cpu_dat_o, host_dat_o, pia_*, busy_o).
REQ-030 Reset during ISSUE or CAPTURE aborts the access: strobe drops immediately, no ack issued; after release, resumes from IDLE with pending requests re-arbitrated.

Verification
REQ-031 CPU read adr 0x04, pia_dat_i=0x5A in CAPTURE -> pia_stb_o cycle N+1 with adr 0x04 we 0, cpu_ack_o cycle N+2, cpu_dat_o=0x5A.
REQ-032 Host write adr 0x16 dat 0x3C alone -> pia_stb_o=1, pia_we_o=1, adr 0x16, dat 0x3C for one cycle; host_ack_o next cycle; host_dat_o unchanged.
REQ-033 Both requesting continuously, STARVE_LIMIT=4 -> grant order CPU,CPU,CPU,CPU,HOST repeating; starve_cnt never exceeds 4.
REQ-034 CPU requests alone 10 times -> starve_cnt stays 0; then contested -> CPU wins.
REQ-035 rst_i low during ISSUE -> pia_stb_o 0 without waiting for clock, no ack; after release held request completes normally.
REQ-036 Requester inputs changed during ISSUE -> PIA bundle still shows latched values.
